// File: rtl/mem_arbiter_fsm_if.sv
// mem_arbiter_fsm_if: core request ports, memory port and responses between environment and arbiter
interface mem_arbiter_fsm_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data_out;
  logic        ien_mem_re;
  logic        ien_mem_wr;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_data_out;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        oen_mem_re;
  logic        oen_mem_wr;
  logic        mem_ready;
  logic [31:0] data_out;
  logic        mem_err;
  modport master (
    output imem_req, imem_addr, ien_mem_re, ien_mem_wr, dmem_addr, dmem_wdata, mem_ready, data_out,
    input  imem_ready, imem_data_out, dmem_ready, dmem_data_out, mem_addr, mem_wdata, oen_mem_re,
           oen_mem_wr, mem_err
  );
  modport slave (
    input  imem_req, imem_addr, ien_mem_re, ien_mem_wr, dmem_addr, dmem_wdata, mem_ready, data_out,
    output imem_ready, imem_data_out, dmem_ready, dmem_data_out, mem_addr, mem_wdata, oen_mem_re,
           oen_mem_wr, mem_err
  );
endinterface

// File: rtl/mem_arbiter_fsm.sv
// mem_arbiter_fsm: shares one main-memory port between fetch and load/store, dmem first with starvation guard
module mem_arbiter_fsm #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input logic              clk,
  input logic              rst,
  mem_arbiter_fsm_if.slave io_bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I, RESP} state_t;
  state_t            r_state, w_state_nxt;
  logic [31:0]       r_addr, r_wdata, r_data;
  logic              r_re, r_wr, r_win_i, r_abort;
  logic [CNT_W-1:0]  r_cnt, w_cnt_inc;
  logic [SW-1:0]     r_starve;
  logic              w_force_i, w_grant_d, w_grant_i, w_serve, w_timeout, w_resp;
  always_comb begin
    w_force_i   = io_bus.imem_req && STARVE_LIMIT != 0 && r_starve == SW'(STARVE_LIMIT);
    w_grant_d   = r_state == IDLE && (io_bus.ien_mem_re || io_bus.ien_mem_wr) && !w_force_i;
    w_grant_i   = r_state == IDLE && !w_grant_d && io_bus.imem_req;
    w_serve     = r_state == SERVE_D || r_state == SERVE_I;
    w_cnt_inc   = r_cnt + 1'b1;
    w_timeout   = TIMEOUT_CYCLES != 0 && w_cnt_inc == CNT_W'(TIMEOUT_CYCLES);
    w_state_nxt = w_grant_d ? SERVE_D :
                  w_grant_i ? SERVE_I :
                  (w_serve && (io_bus.mem_ready || w_timeout)) ? RESP :
                  r_state == RESP ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_data   <= '0;
      r_re     <= 1'b0;
      r_wr     <= 1'b0;
      r_win_i  <= 1'b0;
      r_abort  <= 1'b0;
      r_cnt    <= '0;
      r_starve <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_d || w_grant_i) begin
        r_addr  <= w_grant_d ? io_bus.dmem_addr : io_bus.imem_addr;
        r_wdata <= w_grant_d ? io_bus.dmem_wdata : '0;
        r_wr    <= w_grant_d && io_bus.ien_mem_wr;
        r_re    <= w_grant_i || !io_bus.ien_mem_wr;
        r_win_i <= w_grant_i;
        r_abort <= 1'b0;
        r_cnt   <= '0;
      end
      if (w_serve) r_cnt <= w_cnt_inc;
      // mem_ready takes precedence over a coincident timeout
      if (w_serve && (io_bus.mem_ready || w_timeout)) begin
        r_data  <= (io_bus.mem_ready && r_re) ? io_bus.data_out : '0;
        r_abort <= !io_bus.mem_ready;
        r_re    <= 1'b0;
        r_wr    <= 1'b0;
      end
      if (w_grant_i) r_starve <= '0;
      else if (w_grant_d && io_bus.imem_req && r_starve != SW'(STARVE_LIMIT)) r_starve <= r_starve + 1'b1;
    end
  end
  assign w_resp               = r_state == RESP;
  assign io_bus.imem_ready    = w_resp && r_win_i;
  assign io_bus.dmem_ready    = w_resp && !r_win_i;
  assign io_bus.imem_data_out = io_bus.imem_ready ? r_data : '0;
  assign io_bus.dmem_data_out = io_bus.dmem_ready ? r_data : '0;
  assign io_bus.mem_err       = w_resp && r_abort;
  assign io_bus.mem_addr      = r_addr;
  assign io_bus.mem_wdata     = r_wdata;
  assign io_bus.oen_mem_re    = r_re;
  assign io_bus.oen_mem_wr    = r_wr;
endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// tb_mem_arbiter_fsm: vector table for basic transactions plus sequences for starvation, timeout and reset
module tb_mem_arbiter_fsm;
  typedef struct packed {
    logic rst; logic ireq; logic [31:0] iaddr; logic re; logic wr;
    logic [31:0] daddr; logic [31:0] wdata; logic mrdy; logic [31:0] mdata;
  } in_t;
  typedef struct packed {
    logic ir; logic [31:0] id; logic dr; logic [31:0] dd;
    logic [31:0] ma; logic [31:0] mw; logic re; logic wr; logic err;
  } out_t;
  typedef struct packed { in_t i; out_t o; } vec_t;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  mem_arbiter_fsm_if bus();
  mem_arbiter_fsm #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8), .CNT_W(7)) dut (.clk(clk), .rst(rst), .io_bus(bus));
  always #5 clk = ~clk;
  task automatic apply(input in_t v);
    rst = v.rst; bus.imem_req = v.ireq; bus.imem_addr = v.iaddr; bus.ien_mem_re = v.re;
    bus.ien_mem_wr = v.wr; bus.dmem_addr = v.daddr; bus.dmem_wdata = v.wdata;
    bus.mem_ready = v.mrdy; bus.data_out = v.mdata;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic out_t outs();
    return '{bus.imem_ready, bus.imem_data_out, bus.dmem_ready, bus.dmem_data_out,
             bus.mem_addr, bus.mem_wdata, bus.oen_mem_re, bus.oen_mem_wr, bus.mem_err};
  endfunction
  task automatic check(input string name, input out_t exp);
    out_t act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  function automatic out_t mk(input logic ir, input logic [31:0] id, input logic dr, input logic [31:0] dd,
                              input logic [31:0] ma, input logic [31:0] mw, input logic re, input logic wr,
                              input logic err);
    return '{ir, id, dr, dd, ma, mw, re, wr, err};
  endfunction
  function automatic in_t mi(input logic r, input logic ireq, input logic [31:0] iaddr, input logic re,
                             input logic wr, input logic [31:0] daddr, input logic [31:0] wdata,
                             input logic mrdy, input logic [31:0] mdata);
    return '{r, ireq, iaddr, re, wr, daddr, wdata, mrdy, mdata};
  endfunction
  vec_t vecs [14];
  initial begin
    vecs[0]  = '{mi(1, 0, 0, 0, 0, 0, 0, 0, 0),                               mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{mi(0, 1, 32'h100, 0, 0, 0, 0, 0, 0),                         mk(0, 0, 0, 0, 32'h100, 0, 1, 0, 0)};
    vecs[2]  = '{mi(0, 1, 32'h100, 0, 0, 0, 0, 1, 32'hDEADBEEF),              mk(1, 32'hDEADBEEF, 0, 0, 32'h100, 0, 0, 0, 0)};
    vecs[3]  = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0),                               mk(0, 0, 0, 0, 32'h100, 0, 0, 0, 0)};
    vecs[4]  = '{mi(0, 1, 32'h300, 1, 0, 32'h200, 0, 0, 0),                   mk(0, 0, 0, 0, 32'h200, 0, 1, 0, 0)};
    vecs[5]  = '{mi(0, 1, 32'h300, 1, 0, 32'h200, 0, 1, 32'hA5A5A5A5),        mk(0, 0, 1, 32'hA5A5A5A5, 32'h200, 0, 0, 0, 0)};
    vecs[6]  = '{mi(0, 1, 32'h300, 0, 0, 0, 0, 0, 0),                         mk(0, 0, 0, 0, 32'h200, 0, 0, 0, 0)};
    vecs[7]  = '{mi(0, 1, 32'h300, 0, 0, 0, 0, 0, 0),                         mk(0, 0, 0, 0, 32'h300, 0, 1, 0, 0)};
    vecs[8]  = '{mi(0, 1, 32'h300, 0, 0, 0, 0, 1, 32'h11112222),              mk(1, 32'h11112222, 0, 0, 32'h300, 0, 0, 0, 0)};
    vecs[9]  = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0),                               mk(0, 0, 0, 0, 32'h300, 0, 0, 0, 0)};
    vecs[10] = '{mi(0, 0, 0, 1, 1, 32'h40, 32'h12345678, 0, 0),               mk(0, 0, 0, 0, 32'h40, 32'h12345678, 0, 1, 0)};
    vecs[11] = '{mi(0, 0, 0, 1, 1, 32'h40, 32'h12345678, 1, 32'hFFFFFFFF),    mk(0, 0, 1, 0, 32'h40, 32'h12345678, 0, 0, 0)};
    vecs[12] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0),                               mk(0, 0, 0, 0, 32'h40, 32'h12345678, 0, 0, 0)};
    vecs[13] = '{mi(0, 0, 0, 0, 0, 0, 0, 1, 32'h55),                          mk(0, 0, 0, 0, 32'h40, 32'h12345678, 0, 0, 0)};
    apply(mi(1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    for (int n = 0; n < 14; n++) begin
      apply(vecs[n].i);
      cyc();
      check($sformatf("vec%0d", n), vecs[n].o);
    end
    // starvation: dmem and imem both held; grant 5 must go to imem, grant 6 back to dmem
    apply(mi(0, 1, 32'h500, 1, 0, 32'h600, 32'h77, 0, 0));
    for (int k = 0; k < 6; k++) begin
      logic        gi;
      logic [31:0] ma, mw, d;
      gi = (k == 4);
      ma = gi ? 32'h500 : 32'h600;
      mw = gi ? 32'h0 : 32'h77;
      d  = 32'h600D0000 + 32'(k);
      bus.mem_ready = 1'b0;
      cyc();
      check($sformatf("starve_grant%0d", k), mk(0, 0, 0, 0, ma, mw, 1, 0, 0));
      bus.mem_ready = 1'b1;
      bus.data_out = d;
      cyc();
      check($sformatf("starve_resp%0d", k), mk(gi, gi ? d : 0, !gi, gi ? 0 : d, ma, mw, 0, 0, 0));
      bus.mem_ready = 1'b0;
      cyc();
      check($sformatf("starve_idle%0d", k), mk(0, 0, 0, 0, ma, mw, 0, 0, 0));
    end
    // timeout: 8 serve cycles without mem_ready, abort on the 9th edge
    apply(mi(0, 0, 0, 1, 0, 32'h700, 0, 0, 32'hCAFEF00D));
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (c < 9) check($sformatf("tmo_serve%0d", c), mk(0, 0, 0, 0, 32'h700, 0, 1, 0, 0));
      else check("tmo_abort", mk(0, 0, 1, 0, 32'h700, 0, 0, 0, 1));
    end
    bus.ien_mem_re = 1'b0;
    cyc();
    check("tmo_idle", mk(0, 0, 0, 0, 32'h700, 0, 0, 0, 0));
    // mem_ready coinciding with the timeout edge completes normally
    apply(mi(0, 0, 0, 1, 0, 32'h704, 0, 0, 32'hCAFEF00D));
    for (int c = 1; c <= 9; c++) begin
      bus.mem_ready = (c == 9);
      cyc();
      if (c < 9) check($sformatf("race_serve%0d", c), mk(0, 0, 0, 0, 32'h704, 0, 1, 0, 0));
      else check("race_resp", mk(0, 0, 1, 32'hCAFEF00D, 32'h704, 0, 0, 0, 0));
    end
    apply(mi(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    check("race_idle", mk(0, 0, 0, 0, 32'h704, 0, 0, 0, 0));
    // reset during SERVE_I abandons the fetch; a fresh one then completes
    apply(mi(0, 1, 32'h900, 0, 0, 0, 0, 0, 0));
    cyc();
    check("rst_serve", mk(0, 0, 0, 0, 32'h900, 0, 1, 0, 0));
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.data_out = 32'h0BADCAFE;
    cyc();
    check("rst_abandon", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    cyc();
    check("rst_regrant", mk(0, 0, 0, 0, 32'h900, 0, 1, 0, 0));
    bus.mem_ready = 1'b1;
    cyc();
    check("rst_resp", mk(1, 32'h0BADCAFE, 0, 0, 32'h900, 0, 0, 0, 0));
    apply(mi(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc();
    check("rst_idle", mk(0, 0, 0, 0, 32'h900, 0, 0, 0, 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
